rvga_hazard_ctrl: RTL and testbench

//  Parametrised pipeline hazard/control unit for the rvga in-order core; successor to the fixed 6-stage hazard unit.

---
 rtl/rvga_hazard_ctrl_pkg.sv | 17 +
 rtl/rvga_hazard_sb.sv | 98 +++++++++
 rtl/rvga_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_rvga_hazard_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rvga_hazard_ctrl_pkg.sv
// Shared types for the rvga hazard/control unit: register index, stage index
// and scoreboard entry payload.
package rvga_hazard_ctrl_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned STAGE_IDX_W = 3;

  typedef logic [REG_W-1:0]       rvga_reg;
  typedef logic [STAGE_IDX_W-1:0] rvga_stage_idx;

  typedef struct packed {
    logic    v;
    rvga_reg rd;
    logic    load;
  } rvga_sb_entry_s;

endpackage

// File: rtl/rvga_hazard_sb.sv
// In-flight destination scoreboard for stages after register fetch, with
// youngest-match RAW detection. RVGA_HAZARD_FWD_EN enables bypass selection.
module rvga_hazard_sb
  import rvga_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = 6,
  parameter int unsigned RFETCH_STAGE = 2,
  parameter int unsigned MEM_STAGE    = 4,
  parameter int unsigned SB_DEPTH     = NUM_STAGES - 1 - RFETCH_STAGE,
  parameter int unsigned SEL_W        = $clog2(NUM_STAGES)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [SB_DEPTH:0] i_stall_v,
  input  logic [SB_DEPTH:0] i_flush_v,
  input  logic              i_issue_v,
  input  rvga_reg           i_issue_rd,
  input  logic              i_issue_rd_w_v,
  input  logic              i_issue_load_v,
  input  rvga_reg           i_rs1,
  input  logic              i_rs1_v,
  input  rvga_reg           i_rs2,
  input  logic              i_rs2_v,
  output logic              o_raw_c,
  output logic [SEL_W-1:0]  o_fwd_rs1_sel_c,
  output logic [SEL_W-1:0]  o_fwd_rs2_sel_c
);

`ifdef RVGA_HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  rvga_sb_entry_s r_sb   [SB_DEPTH];
  rvga_sb_entry_s w_sb_in[SB_DEPTH];
  rvga_reg        w_rs   [2];
  logic [1:0]     w_rs_v;
  logic [1:0]     w_hit;
  logic [1:0]     w_lu;
  logic [1:0]     w_raw;
  logic [SEL_W-1:0] w_stage[2];
  logic [SEL_W-1:0] w_sel  [2];

  // Shift source: entry 0 takes the issuing instruction, others the younger entry
  always_comb begin
    w_sb_in[0].v    = i_issue_v && i_issue_rd_w_v && (i_issue_rd != '0);
    w_sb_in[0].rd   = i_issue_rd;
    w_sb_in[0].load = i_issue_load_v;
    for (int unsigned j = 1; j < SB_DEPTH; j++) begin
      w_sb_in[j] = r_sb[j-1];
    end
  end

  // Index 0 of the stall/flush slices is RFETCH_STAGE; entry j sits at index j+1
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned j = 0; j < SB_DEPTH; j++) r_sb[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < SB_DEPTH; j++) begin
        if (i_flush_v[j+1]) begin
          r_sb[j] <= '0;
        end else if (!i_stall_v[j+1]) begin
          if (j == 0 && (i_stall_v[0] || i_flush_v[0])) r_sb[j] <= '0;
          else                                          r_sb[j] <= w_sb_in[j];
        end
      end
    end
  end

  assign w_rs[0]   = i_rs1;
  assign w_rs[1]   = i_rs2;
  assign w_rs_v[0] = i_rs1_v;
  assign w_rs_v[1] = i_rs2_v;

  // Walk oldest to youngest so the lowest matching entry wins
  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      w_hit[s]   = 1'b0;
      w_lu[s]    = 1'b0;
      w_stage[s] = '0;
      for (int j = int'(SB_DEPTH) - 1; j >= 0; j--) begin
        if (w_rs_v[s] && (w_rs[s] != '0) && r_sb[j].v && (r_sb[j].rd == w_rs[s])) begin
          w_hit[s]   = 1'b1;
          w_stage[s] = SEL_W'(RFETCH_STAGE + 1 + unsigned'(j));
          w_lu[s]    = r_sb[j].load && ((RFETCH_STAGE + 1 + unsigned'(j)) <= MEM_STAGE);
        end
      end
      w_raw[s] = FWD_EN ? w_lu[s] : w_hit[s];
      w_sel[s] = (FWD_EN && w_hit[s] && !w_lu[s]) ? w_stage[s] : '0;
    end
  end

  assign o_raw_c         = |w_raw;
  assign o_fwd_rs1_sel_c = w_sel[0];
  assign o_fwd_rs2_sel_c = w_sel[1];

endmodule

// File: rtl/rvga_hazard_ctrl.sv
// Pipeline hazard/control unit: per-stage stall/flush, branch priority and
// saturating stall counter. Define RVGA_HAZARD_FWD_EN for bypass operation.
module rvga_hazard_ctrl
  import rvga_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = 6,
  parameter int unsigned RFETCH_STAGE = 2,
  parameter int unsigned MEM_STAGE    = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          imem_read_v_i,
  input  logic                          imem_resp_v_i,
  input  logic                          dmem_read_v_i,
  input  logic                          dmem_resp_v_i,
  input  logic [NUM_STAGES-1:0]         br_v_i,
  input  rvga_reg                       rs1_i,
  input  rvga_reg                       rs2_i,
  input  logic                          rs1_v_i,
  input  logic                          rs2_v_i,
  input  logic                          issue_v_i,
  input  rvga_reg                       issue_rd_i,
  input  logic                          issue_rd_w_v_i,
  input  logic                          issue_load_v_i,
  output logic [NUM_STAGES-1:0]         stall_v_o,
  output logic [NUM_STAGES-1:0]         flush_v_o,
  output logic [$clog2(NUM_STAGES)-1:0] fwd_rs1_sel_o,
  output logic [$clog2(NUM_STAGES)-1:0] fwd_rs2_sel_o,
  output logic [CNT_W-1:0]              stall_cnt_o
);

  localparam int unsigned SB_DEPTH = NUM_STAGES - 1 - RFETCH_STAGE;
  localparam int unsigned SEL_W    = $clog2(NUM_STAGES);

  logic [NUM_STAGES-1:0] w_stall_pre;
  logic [NUM_STAGES-1:0] w_br_mask;
  logic [NUM_STAGES-1:0] w_stall;
  logic [NUM_STAGES-1:0] w_flush;
  logic                  w_raw;
  logic                  w_imem_wait;
  logic                  w_dmem_wait;
  logic [SEL_W-1:0]      w_fwd_rs1_sel;
  logic [SEL_W-1:0]      w_fwd_rs2_sel;
  logic [CNT_W-1:0]      r_stall_cnt;

  assign w_imem_wait = imem_read_v_i && !imem_resp_v_i;
  assign w_dmem_wait = dmem_read_v_i && !dmem_resp_v_i;

  // Stall sources, branch override (highest unstalled redirect wins), then bubbles
  always_comb begin
    w_stall_pre = '0;
    w_br_mask   = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      w_stall_pre[i] = (w_imem_wait && i == 0) ||
                       (w_dmem_wait && i <= MEM_STAGE) ||
                       (w_raw && i <= RFETCH_STAGE);
    end
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (br_v_i[i] && !w_stall_pre[i]) begin
        for (int unsigned m = 0; m < NUM_STAGES; m++) w_br_mask[m] = (m < i);
      end
    end
    w_stall = w_stall_pre & ~w_br_mask;
    w_flush = w_br_mask;
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      w_flush[i] = w_flush[i] | (w_stall[i-1] && !w_stall[i]);
    end
    if (rst_i) begin
      w_stall = '0;
      w_flush = '1;
    end
  end

  rvga_hazard_sb #(
    .NUM_STAGES   (NUM_STAGES),
    .RFETCH_STAGE (RFETCH_STAGE),
    .MEM_STAGE    (MEM_STAGE),
    .SB_DEPTH     (SB_DEPTH),
    .SEL_W        (SEL_W)
  ) u_sb (
    .i_clk           (clk_i),
    .i_rst           (rst_i),
    .i_stall_v       (w_stall[NUM_STAGES-1:RFETCH_STAGE]),
    .i_flush_v       (w_flush[NUM_STAGES-1:RFETCH_STAGE]),
    .i_issue_v       (issue_v_i),
    .i_issue_rd      (issue_rd_i),
    .i_issue_rd_w_v  (issue_rd_w_v_i),
    .i_issue_load_v  (issue_load_v_i),
    .i_rs1           (rs1_i),
    .i_rs1_v         (rs1_v_i),
    .i_rs2           (rs2_i),
    .i_rs2_v         (rs2_v_i),
    .o_raw_c         (w_raw),
    .o_fwd_rs1_sel_c (w_fwd_rs1_sel),
    .o_fwd_rs2_sel_c (w_fwd_rs2_sel)
  );

  // Counts fetch-stall cycles, sticking at all-ones
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall[0] && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_v_o     = w_stall;
  assign flush_v_o     = w_flush;
  assign fwd_rs1_sel_o = rst_i ? '0 : w_fwd_rs1_sel;
  assign fwd_rs2_sel_o = rst_i ? '0 : w_fwd_rs2_sel;
  assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_rvga_hazard_ctrl.sv
// Self-checking bench for rvga_hazard_ctrl: directed scenarios then random
// traffic against a stage-indexed pipeline model of the hazard rules.
module tb_rvga_hazard_ctrl;
  import rvga_hazard_ctrl_pkg::*;

  localparam int unsigned NS  = 6;
  localparam int unsigned RF  = 2;
  localparam int unsigned MS  = 4;
  localparam int unsigned CW  = 4;
  localparam int unsigned SW  = 3;
  localparam int          MAX_CNT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, imem_read_v, imem_resp_v, dmem_read_v, dmem_resp_v;
  logic [NS-1:0] br_v;
  rvga_reg       rs1, rs2, issue_rd;
  logic          rs1_v, rs2_v, issue_v, issue_rd_w_v, issue_load_v;
  logic [NS-1:0] stall_v, flush_v;
  logic [SW-1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic [CW-1:0] stall_cnt;

  rvga_hazard_ctrl #(
    .NUM_STAGES(NS), .RFETCH_STAGE(RF), .MEM_STAGE(MS), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_read_v_i(imem_read_v), .imem_resp_v_i(imem_resp_v),
    .dmem_read_v_i(dmem_read_v), .dmem_resp_v_i(dmem_resp_v),
    .br_v_i(br_v), .rs1_i(rs1), .rs2_i(rs2), .rs1_v_i(rs1_v), .rs2_v_i(rs2_v),
    .issue_v_i(issue_v), .issue_rd_i(issue_rd), .issue_rd_w_v_i(issue_rd_w_v),
    .issue_load_v_i(issue_load_v),
    .stall_v_o(stall_v), .flush_v_o(flush_v),
    .fwd_rs1_sel_o(fwd_rs1_sel), .fwd_rs2_sel_o(fwd_rs2_sel),
    .stall_cnt_o(stall_cnt)
  );

  typedef struct { bit v; bit [4:0] rd; bit load; } ent_t;
  ent_t pipe[NS];
  int   mcnt;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; imem_read_v = 1'b0; imem_resp_v = 1'b0;
    dmem_read_v = 1'b0; dmem_resp_v = 1'b0; br_v = '0;
    rs1 = '0; rs2 = '0; rs1_v = 1'b0; rs2_v = 1'b0;
    issue_v = 1'b0; issue_rd = '0; issue_rd_w_v = 1'b0; issue_load_v = 1'b0;
  endtask

  // One cycle: predict outputs from the rules, compare, then advance the model at posedge
  task automatic step(input string tag);
    int            hi, k, found;
    bit            raw;
    logic [NS-1:0] es, ef;
    logic [SW-1:0] sel[2];
    rvga_reg       rs;
    logic          rv;
    ent_t          nxt[NS];
    #1;
    hi = -1; raw = 1'b0; sel[0] = '0; sel[1] = '0;
    if (imem_read_v && !imem_resp_v) hi = 0;
    if (dmem_read_v && !dmem_resp_v) hi = MS;
    for (int s = 0; s < 2; s++) begin
      rs = (s == 0) ? rs1 : rs2;
      rv = (s == 0) ? rs1_v : rs2_v;
      found = -1;
      for (int st = RF + 1; st < NS; st++)
        if (found < 0 && pipe[st].v && pipe[st].rd == rs) found = st;
      if (rv && rs != 0 && found >= 0) begin
`ifdef RVGA_HAZARD_FWD_EN
        if (pipe[found].load && found <= MS) raw = 1'b1;
        else sel[s] = SW'(found);
`else
        raw = 1'b1;
`endif
      end
    end
    if (raw && hi < int'(RF)) hi = RF;
    k = -1;
    for (int i = 0; i < NS; i++) if (br_v[i] && i > hi) k = i;
    if (k >= 0) begin
      es = '0;
      ef = NS'((32'd1 << k) - 32'd1);
    end else begin
      es = (hi >= 0) ? NS'((32'd1 << (hi + 1)) - 32'd1) : '0;
      ef = (hi >= 0 && hi < NS - 1) ? NS'(32'd1 << (hi + 1)) : '0;
    end
    if (rst) begin
      es = '0; ef = '1; sel[0] = '0; sel[1] = '0;
    end
    check({tag, ".stall"}, 32'(stall_v), 32'(es));
    check({tag, ".flush"}, 32'(flush_v), 32'(ef));
    check({tag, ".fwd1"}, 32'(fwd_rs1_sel), 32'(sel[0]));
    check({tag, ".fwd2"}, 32'(fwd_rs2_sel), 32'(sel[1]));
    check({tag, ".cnt"}, 32'(stall_cnt), 32'(mcnt));
    @(posedge clk);
    if (rst) begin
      mcnt = 0;
      for (int st = 0; st < NS; st++) pipe[st] = '{default: 0};
    end else begin
      if (es[0] && mcnt < MAX_CNT) mcnt++;
      for (int st = 0; st < NS; st++) nxt[st] = pipe[st];
      for (int st = RF + 1; st < NS; st++) begin
        if (ef[st]) nxt[st] = '{default: 0};
        else if (es[st]) nxt[st] = pipe[st];
        else if (st == RF + 1) begin
          if (es[RF] || ef[RF]) nxt[st] = '{default: 0};
          else nxt[st] = '{v: issue_v && issue_rd_w_v && issue_rd != 0, rd: issue_rd, load: issue_load_v};
        end else nxt[st] = pipe[st-1];
      end
      for (int st = 0; st < NS; st++) pipe[st] = nxt[st];
    end
    @(negedge clk);
  endtask

  initial begin
    mcnt = 0;
    for (int st = 0; st < NS; st++) pipe[st] = '{default: 0};
    idle();
    @(negedge clk);
    rst = 1'b1;
    step("reset0"); step("reset1");
    rst = 1'b0;

    imem_read_v = 1'b1;
    repeat (3) step("imem");
    check("imem_cnt3", 32'(stall_cnt), 32'd3);
    imem_resp_v = 1'b1; step("imem_resp");
    idle();

    issue_v = 1'b1; issue_rd = 5'd9; issue_rd_w_v = 1'b1; step("pre_dmem");
    idle(); dmem_read_v = 1'b1;
    repeat (2) step("dmem");
    dmem_resp_v = 1'b1; step("dmem_resp");
    idle(); repeat (3) step("drain0");

    issue_v = 1'b1; issue_rd = 5'd5; issue_rd_w_v = 1'b1; step("alu_x5");
    issue_rd = 5'd6; rs1 = 5'd5; rs1_v = 1'b1;
    repeat (4) step("raw_x5");
    idle(); repeat (3) step("drain1");

    issue_v = 1'b1; issue_rd = 5'd7; issue_rd_w_v = 1'b1; issue_load_v = 1'b1; step("load_x7");
    idle(); issue_v = 1'b1; rs2 = 5'd7; rs2_v = 1'b1;
    repeat (4) step("use_x7");
    idle(); repeat (3) step("drain2");

    issue_v = 1'b1; issue_rd = 5'd3; issue_rd_w_v = 1'b1; step("alu_x3");
    idle(); rs1 = 5'd3; rs1_v = 1'b1; step("raw_x3");
    br_v = 6'b001000; step("branch3");
    br_v = '0; step("post_branch");
    idle(); repeat (3) step("drain3");

    issue_v = 1'b1; issue_rd = 5'd4; issue_rd_w_v = 1'b1; step("alu_x4");
    idle(); dmem_read_v = 1'b1; step("dmem_pre_rst");
    rst = 1'b1; step("rst_mid");
    check("rst_cnt0", 32'(stall_cnt), 32'd0);
    idle(); rs1 = 5'd4; rs1_v = 1'b1; step("post_rst_x4");
    issue_v = 1'b1; issue_rd = 5'd0; issue_rd_w_v = 1'b1; rs1 = 5'd0; rs2 = 5'd0; rs2_v = 1'b1;
    repeat (3) step("x0_src");

    idle(); imem_read_v = 1'b1;
    repeat (20) step("sat");
    check("sat_cnt", 32'(stall_cnt), 32'(MAX_CNT));
    idle();

    repeat (600) begin
      rst          = ($urandom_range(0, 59) == 0);
      imem_read_v  = $urandom_range(0, 3) == 0;
      imem_resp_v  = $urandom_range(0, 1) == 1;
      dmem_read_v  = $urandom_range(0, 5) == 0;
      dmem_resp_v  = $urandom_range(0, 1) == 1;
      br_v         = ($urandom_range(0, 7) == 0) ? NS'($urandom) : '0;
      rs1          = rvga_reg'($urandom_range(0, 4));
      rs2          = rvga_reg'($urandom_range(0, 4));
      rs1_v        = $urandom_range(0, 1) == 1;
      rs2_v        = $urandom_range(0, 1) == 1;
      issue_v      = $urandom_range(0, 3) != 0;
      issue_rd     = rvga_reg'($urandom_range(0, 4));
      issue_rd_w_v = $urandom_range(0, 3) != 0;
      issue_load_v = $urandom_range(0, 2) == 0;
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
